decode_stage: RTL and testbench

//  Parametrised decode stage between fetchBuffer and rename. Decodes up to WIDTH insts/cycle, assigns

---
 rtl/decode_stage.sv | 176 +++++++++++++++++
 tb/tb_decode_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage between the fetch buffer and rename: decodes up to WIDTH slots per cycle,
// assigns speculative PCs, tags illegal instructions and serialises CSR/fence-class instructions.
module decode_stage #(
    parameter int              WIDTH   = 4,
    parameter int              XLEN    = 64,
    parameter int              ILEN    = 32,
    parameter logic [XLEN-1:0] INIT_PC = XLEN'('h8000_0000),
    localparam int             EXC_W   = 4,
    localparam int             DEC_W   = 2*XLEN + EXC_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_squash_vld,
    input  logic [XLEN-1:0]        i_squash_pc,
    input  logic [WIDTH-1:0]       i_inst_vld,
    input  logic [WIDTH*ILEN-1:0]  i_inst,
    input  logic [WIDTH*XLEN-1:0]  i_inst_npc,
    output logic [WIDTH-1:0]       o_can_deq,
    input  logic                   i_stall,
    input  logic                   i_rob_empty,
    input  logic                   i_serial_commit,
    output logic [WIDTH-1:0]       o_decinfo_vld,
    output logic [WIDTH*DEC_W-1:0] o_decinfo
);

    // Per-slot record, low to high: pc, npc, except code, serialize.
    localparam logic [EXC_W-1:0] EXC_NONE    = '0;
    localparam logic [EXC_W-1:0] EXC_ILLEGAL = EXC_W'(2);

    typedef enum logic [1:0] {RUN, DRAIN, WAIT, HALT} state_t;

    state_t                         state, state_nxt;
    logic [XLEN-1:0]                spec_pc_base;
    logic [WIDTH-1:0]               cand_p0, illegal_p0, serial_p0, accept_p0, take_p0;
    logic [WIDTH-1:0][XLEN-1:0]     pc_p0, npc_p0;
    logic [WIDTH-1:0][DEC_W-1:0]    info_p0;
    logic [XLEN-1:0]                last_npc_p0;
    logic                           chain, stop, goes_halt, goes_drain;
    logic                           load, out_busy;

    function automatic logic is_legal(input logic [ILEN-1:0] inst);
        logic ok;
        case (inst[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b0011011, 7'b0111011, 7'b0001111,
            7'b1110011: ok = 1'b1;
            default:    ok = 1'b0;
        endcase
        // All-zeros and all-ones encodings are architecturally reserved as illegal.
        return ok && (|inst) && !(&inst);
    endfunction

    function automatic logic is_serial(input logic [6:0] opcode);
        return (opcode == 7'b1110011) || (opcode == 7'b0001111);
    endfunction

    assign out_busy = |o_decinfo_vld;
    assign load     = !o_decinfo_vld[0] || !i_stall;

    // Stage p0: per-slot decode and PC assignment
    always_comb begin
        chain      = 1'b1;
        cand_p0    = '0;
        illegal_p0 = '0;
        serial_p0  = '0;
        pc_p0      = '0;
        npc_p0     = '0;
        info_p0    = '0;
        pc_p0[0]   = spec_pc_base;
        for (int k = 1; k < WIDTH; k++) begin
            pc_p0[k] = i_inst_npc[(k-1)*XLEN +: XLEN];
        end
        for (int k = 0; k < WIDTH; k++) begin
            chain         = chain & i_inst_vld[k];
            cand_p0[k]    = chain;
            npc_p0[k]     = i_inst_npc[k*XLEN +: XLEN];
            illegal_p0[k] = !is_legal(i_inst[k*ILEN +: ILEN]);
            serial_p0[k]  = is_serial(i_inst[k*ILEN +: 7]);
            info_p0[k]    = {serial_p0[k], illegal_p0[k] ? EXC_ILLEGAL : EXC_NONE,
                             npc_p0[k], pc_p0[k]};
        end
    end

    // Walk the candidate slots in order; the first illegal or serialising slot ends the group.
    always_comb begin
        accept_p0  = '0;
        stop       = 1'b0;
        goes_halt  = 1'b0;
        goes_drain = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!stop) begin
                if (!cand_p0[k]) begin
                    stop = 1'b1;
                end else if (illegal_p0[k]) begin
                    accept_p0[k] = 1'b1;
                    goes_halt    = 1'b1;
                    stop         = 1'b1;
                end else if (serial_p0[k]) begin
                    goes_drain = (k == 0);
                    stop       = 1'b1;
                end else begin
                    accept_p0[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take_p0   = '0;
        if (i_squash_vld) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (load) begin
                        take_p0 = accept_p0;
                        if (goes_halt) begin
                            state_nxt = HALT;
                        end else if (goes_drain) begin
                            state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // An empty output register implies load, so the serialiser goes out alone.
                    if (i_rob_empty && !out_busy && i_inst_vld[0]) begin
                        take_p0   = WIDTH'(1);
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (i_serial_commit) begin
                        state_nxt = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        last_npc_p0 = spec_pc_base;
        for (int k = 0; k < WIDTH; k++) begin
            if (take_p0[k]) begin
                last_npc_p0 = npc_p0[k];
            end
        end
    end

    assign o_can_deq = take_p0 & {WIDTH{rst}};

    // Stage p1: registered decode info toward rename
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            spec_pc_base  <= INIT_PC;
            o_decinfo_vld <= '0;
            o_decinfo     <= '0;
        end else begin
            state <= state_nxt;
            if (i_squash_vld) begin
                o_decinfo_vld <= '0;
                spec_pc_base  <= i_squash_pc;
            end else if (load) begin
                o_decinfo_vld <= take_p0;
                o_decinfo     <= info_p0;
                if (|take_p0) begin
                    spec_pc_base <= last_npc_p0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a slot-walking reference model checked every cycle.
module tb_decode_stage;

    localparam int W  = 4;
    localparam int XL = 64;
    localparam int IL = 32;
    localparam int EW = 4;
    localparam int DW = 2*XL + EW + 1;

    localparam logic [IL-1:0] ALU = 32'h0010_0093;
    localparam logic [IL-1:0] CSR = 32'h3402_9073;
    localparam logic [IL-1:0] ILL = 32'h0000_0000;

    localparam int M_RUN = 0, M_DRAIN = 1, M_WAIT = 2, M_HALT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_squash_vld = 1'b0;
    logic [XL-1:0]    i_squash_pc = '0;
    logic [W-1:0]     i_inst_vld = '0;
    logic [W*IL-1:0]  i_inst = '0;
    logic [W*XL-1:0]  i_inst_npc = '0;
    logic [W-1:0]     o_can_deq;
    logic             i_stall = 1'b0;
    logic             i_rob_empty = 1'b1;
    logic             i_serial_commit = 1'b0;
    logic [W-1:0]     o_decinfo_vld;
    logic [W*DW-1:0]  o_decinfo;

    decode_stage #(.WIDTH(W), .XLEN(XL), .ILEN(IL), .INIT_PC(64'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .i_squash_vld(i_squash_vld), .i_squash_pc(i_squash_pc),
        .i_inst_vld(i_inst_vld), .i_inst(i_inst), .i_inst_npc(i_inst_npc),
        .o_can_deq(o_can_deq), .i_stall(i_stall), .i_rob_empty(i_rob_empty),
        .i_serial_commit(i_serial_commit),
        .o_decinfo_vld(o_decinfo_vld), .o_decinfo(o_decinfo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [XL-1:0] f_pc(input int s);
        return o_decinfo[s*DW +: XL];
    endfunction
    function automatic logic [XL-1:0] f_npc(input int s);
        return o_decinfo[s*DW+XL +: XL];
    endfunction
    function automatic logic [EW-1:0] f_exc(input int s);
        return o_decinfo[s*DW+2*XL +: EW];
    endfunction
    function automatic logic f_ser(input int s);
        return o_decinfo[s*DW+DW-1];
    endfunction

    function automatic logic legal_inst(input logic [IL-1:0] inst);
        if (inst == '0 || inst == '1) return 1'b0;
        return inst[6:0] inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23,
                                 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h0f, 7'h73};
    endfunction
    function automatic logic serial_inst(input logic [IL-1:0] inst);
        return inst[6:0] inside {7'h73, 7'h0f};
    endfunction

    // Reference model: what rename should be holding, plus the decoder's own state.
    logic [W-1:0]  m_vld;
    logic [XL-1:0] m_pc  [W];
    logic [XL-1:0] m_npc [W];
    logic [EW-1:0] m_exc [W];
    logic          m_ser [W];
    logic [XL-1:0] m_base;
    int            m_mode;

    always @(negedge clk) begin : compare
        int            n;
        int            nmode;
        logic [W-1:0]  exp_deq;
        logic [IL-1:0] inst;
        if (!rst) begin
            m_vld  = '0;
            m_base = 64'h8000_0000;
            m_mode = M_RUN;
            chk("rst_vld", 128'(o_decinfo_vld), 128'(0));
            chk("rst_info_zero", 128'(o_decinfo == '0), 128'(1));
            chk("rst_deq", 128'(o_can_deq), 128'(0));
        end else begin
            chk("vld", 128'(o_decinfo_vld), 128'(m_vld));
            for (int s = 0; s < W; s++) begin
                if (m_vld[s]) begin
                    chk($sformatf("pc%0d", s),  128'(f_pc(s)),  128'(m_pc[s]));
                    chk($sformatf("npc%0d", s), 128'(f_npc(s)), 128'(m_npc[s]));
                    chk($sformatf("exc%0d", s), 128'(f_exc(s)), 128'(m_exc[s]));
                    chk($sformatf("ser%0d", s), 128'(f_ser(s)), 128'(m_ser[s]));
                end
            end
            n = 0;
            nmode = m_mode;
            exp_deq = '0;
            if (i_squash_vld) begin
                m_vld  = '0;
                m_base = i_squash_pc;
                nmode  = M_RUN;
            end else begin
                if (m_mode == M_WAIT && i_serial_commit) nmode = M_RUN;
                if (!m_vld[0] || !i_stall) begin
                    if (m_mode == M_RUN) begin
                        while (n < W && i_inst_vld[n]) begin
                            inst = i_inst[n*IL +: IL];
                            if (!legal_inst(inst)) begin
                                n++;
                                nmode = M_HALT;
                                break;
                            end
                            if (serial_inst(inst)) begin
                                if (n == 0) nmode = M_DRAIN;
                                break;
                            end
                            n++;
                        end
                    end else if (m_mode == M_DRAIN && i_rob_empty && m_vld == '0 && i_inst_vld[0]) begin
                        n = 1;
                        nmode = M_WAIT;
                    end
                    exp_deq = W'((1 << n) - 1);
                    for (int s = 0; s < W; s++) begin
                        inst     = i_inst[s*IL +: IL];
                        m_vld[s] = (s < n);
                        if (s == 0) m_pc[s] = m_base;
                        else        m_pc[s] = i_inst_npc[(s-1)*XL +: XL];
                        m_npc[s] = i_inst_npc[s*XL +: XL];
                        m_exc[s] = legal_inst(inst) ? 4'd0 : 4'd2;
                        m_ser[s] = serial_inst(inst);
                    end
                    if (n > 0) m_base = i_inst_npc[(n-1)*XL +: XL];
                end
            end
            m_mode = nmode;
            chk("deq", 128'(o_can_deq), 128'(exp_deq));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grp(input logic [W-1:0] v, input logic [IL-1:0] a, input logic [IL-1:0] b,
                       input logic [IL-1:0] c, input logic [IL-1:0] d, input logic [XL-1:0] pc0);
        i_inst_vld = v;
        i_inst     = {d, c, b, a};
        for (int k = 0; k < W; k++) begin
            i_inst_npc[k*XL +: XL] = pc0 + XL'(4*(k+1));
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t0_deq_in_reset", 128'(o_can_deq), 128'(0));
        chk("t0_vld_in_reset", 128'(o_decinfo_vld), 128'(0));

        // 1: full group of ALU ops
        rst = 1'b1;
        grp(4'b1111, ALU, ALU, ALU, ALU, 64'h8000_0000);
        #1 chk("t1_deq", 128'(o_can_deq), 128'(4'b1111));
        tick();
        chk("t1_vld", 128'(o_decinfo_vld), 128'(4'b1111));
        chk("t1_pc0", 128'(f_pc(0)), 128'(64'h8000_0000));
        chk("t1_pc1", 128'(f_pc(1)), 128'(64'h8000_0004));
        chk("t1_pc2", 128'(f_pc(2)), 128'(64'h8000_0008));
        chk("t1_pc3", 128'(f_pc(3)), 128'(64'h8000_000C));

        // 2: hole in the valid mask
        grp(4'b1011, ALU, ALU, ALU, ALU, 64'h8000_0010);
        #1 chk("t2_deq", 128'(o_can_deq), 128'(4'b0011));
        tick();
        chk("t2_vld", 128'(o_decinfo_vld), 128'(4'b0011));

        // 3: stall with the output full
        i_stall = 1'b1;
        grp(4'b1111, ALU, ALU, ALU, ALU, 64'h8000_0018);
        for (int c = 0; c < 3; c++) begin
            #1 chk("t3_deq_stalled", 128'(o_can_deq), 128'(0));
            tick();
            chk("t3_vld_held", 128'(o_decinfo_vld), 128'(4'b0011));
        end
        i_stall = 1'b0;
        #1 chk("t3_deq_release", 128'(o_can_deq), 128'(4'b1111));
        tick();
        chk("t3_pc0", 128'(f_pc(0)), 128'(64'h8000_0018));

        // 4: CSR in slot 2, then serialised behind the ROB
        grp(4'b1111, ALU, ALU, CSR, ALU, 64'h8000_0028);
        #1 chk("t4_deq_trunc", 128'(o_can_deq), 128'(4'b0011));
        tick();
        i_rob_empty = 1'b0;
        grp(4'b1111, CSR, ALU, ALU, ALU, 64'h8000_0030);
        #1 chk("t4_deq_csr_head", 128'(o_can_deq), 128'(0));
        tick();
        repeat (5) begin
            chk("t4_deq_rob_busy", 128'(o_can_deq), 128'(0));
            tick();
        end
        chk("t4_vld_empty", 128'(o_decinfo_vld), 128'(0));
        i_rob_empty = 1'b1;
        #1 chk("t4_deq_issue", 128'(o_can_deq), 128'(4'b0001));
        tick();
        chk("t4_vld_alone", 128'(o_decinfo_vld), 128'(4'b0001));
        chk("t4_ser_bit", 128'(f_ser(0)), 128'(1));
        chk("t4_csr_pc", 128'(f_pc(0)), 128'(64'h8000_0030));
        grp(4'b1111, ALU, ALU, ALU, ALU, 64'h8000_0034);
        repeat (2) begin
            chk("t4_deq_wait", 128'(o_can_deq), 128'(0));
            tick();
        end
        i_serial_commit = 1'b1;
        #1 chk("t4_deq_commit_cycle", 128'(o_can_deq), 128'(0));
        tick();
        i_serial_commit = 1'b0;
        #1 chk("t4_deq_resume", 128'(o_can_deq), 128'(4'b1111));
        tick();

        // 5: illegal in slot 1 halts decode
        grp(4'b1111, ALU, ILL, ALU, ALU, 64'h8000_0044);
        #1 chk("t5_deq", 128'(o_can_deq), 128'(4'b0011));
        tick();
        chk("t5_vld", 128'(o_decinfo_vld), 128'(4'b0011));
        chk("t5_exc1", 128'(f_exc(1)), 128'(2));
        chk("t5_exc0", 128'(f_exc(0)), 128'(0));
        i_stall = 1'b1;
        grp(4'b1111, ALU, ALU, ALU, ALU, 64'h8000_004C);
        repeat (2) begin
            chk("t5_deq_halted", 128'(o_can_deq), 128'(0));
            tick();
        end

        // 6: squash with the output full and stalled
        i_squash_vld = 1'b1;
        i_squash_pc  = 64'h8000_1000;
        #1 chk("t6_deq_squash", 128'(o_can_deq), 128'(0));
        tick();
        chk("t6_vld_cleared", 128'(o_decinfo_vld), 128'(0));
        i_squash_vld = 1'b0;
        grp(4'b1111, ALU, ALU, ALU, ALU, 64'h8000_1000);
        #1 chk("t6_deq_stall_empty", 128'(o_can_deq), 128'(4'b1111));
        tick();
        chk("t6_pc0", 128'(f_pc(0)), 128'(64'h8000_1000));

        // Async reset in mid-cycle with a held group
        #2 rst = 1'b0;
        #1 chk("t7_vld_async", 128'(o_decinfo_vld), 128'(0));
        chk("t7_deq_async", 128'(o_can_deq), 128'(0));
        tick();
        rst = 1'b1;
        i_stall = 1'b0;
        grp(4'b0001, ALU, ALU, ALU, ALU, 64'h8000_0000);
        #1 chk("t7_deq_after", 128'(o_can_deq), 128'(4'b0001));
        tick();
        chk("t7_pc0", 128'(f_pc(0)), 128'(64'h8000_0000));
        i_inst_vld = '0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
